pulse_det: RTL

PULSE_DET -- requirements
Module: pulse_det

---
 rtl/pulse_pkg.sv | 45 ++++
 rtl/pulse_scan.sv | 48 ++++
 rtl/pulse_det.sv | 130 +++++++++++++
 3 files changed

// File: rtl/pulse_pkg.sv
// Shared types and bit-counting helpers for the pulse detector.
//   state_t    : IDLE / HIGH measurement state
//   lead_ones  : number of consecutive 1s from bit n-1 downward
//   lead_zeros : number of consecutive 0s from bit n-1 downward
package pulse_pkg;

  // Largest sample word the helpers can scan; callers zero-extend into this.
  localparam int MAX_DW = 256;

  typedef enum logic {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  // Count 1s starting at bit n-1 and stopping at the first 0.
  function automatic int lead_ones(input logic [MAX_DW-1:0] w, input int n);
    int   cnt;
    logic done;
    cnt  = 0;
    done = 1'b0;
    for (int i = MAX_DW - 1; i >= 0; i--) begin
      if (i < n && !done) begin
        if (w[i]) cnt++;
        else      done = 1'b1;
      end
    end
    return cnt;
  endfunction

  // Count 0s starting at bit n-1 and stopping at the first 1.
  function automatic int lead_zeros(input logic [MAX_DW-1:0] w, input int n);
    int   cnt;
    logic done;
    cnt  = 0;
    done = 1'b0;
    for (int i = MAX_DW - 1; i >= 0; i--) begin
      if (i < n && !done) begin
        if (!w[i]) cnt++;
        else       done = 1'b1;
      end
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pulse_scan.sv
// Combinational scan of one sample word (MSB = earliest sample).
//   word        : sample word
//   prev        : last sample of the previous accepted word
//   found       : word contains a rising edge
//   edge_off    : offset of the first rising edge from the MSB
//   run_len     : length of the run of 1s starting at that edge
//   end_in_word : that run is terminated by a 0 inside this word
//   extra_edge  : another rising edge follows the terminating 0
module pulse_scan
  import pulse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]         word,
  input  logic                          prev,
  output logic                          found,
  output logic [$clog2(DATA_WIDTH)-1:0] edge_off,
  output logic [$clog2(DATA_WIDTH+1)-1:0] run_len,
  output logic                          end_in_word,
  output logic                          extra_edge
);

  localparam int unsigned OW   = $clog2(DATA_WIDTH);
  localparam int unsigned RW   = $clog2(DATA_WIDTH + 1);
  localparam int          DW_I = int'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] edges_c;
  logic [DATA_WIDTH-1:0] shifted_c;
  logic [DATA_WIDTH-1:0] tail_c;
  int                    off_c;
  int                    run_c;

  // Each sample compared with the one before it; prev precedes the MSB.
  always_comb begin
    edges_c     = word & ~{prev, word[DATA_WIDTH-1:1]};
    found       = |edges_c;
    off_c       = lead_zeros(MAX_DW'(edges_c), DW_I);
    shifted_c   = word << off_c;
    run_c       = lead_ones(MAX_DW'(shifted_c), DW_I);
    end_in_word = found && ((off_c + run_c) < DW_I);
    // Any 1 after the terminating 0 implies a rising edge there.
    tail_c      = word << (off_c + run_c + 1);
    extra_edge  = end_in_word && (|tail_c);
    edge_off    = OW'(off_c);
    run_len     = RW'(run_c);
  end

endmodule

// File: rtl/pulse_det.sv
// Pulse-width detector over a stream of multi-sample words.
//   clk, rst  : clock and synchronous active-high reset
//   i_valid   : i_data carries a sample word this cycle
//   i_data    : samples, MSB earliest, bit 0 latest
//   o_pulse   : one-cycle strobe, a pulse measurement completed
//   o_width   : pulse width in samples (saturating at MAX_SAMPLES)
//   o_offset  : rising-edge offset from the MSB of the start word
//   o_sat     : width reached MAX_SAMPLES during the reported pulse
//   o_missed  : one-cycle flag, a rising edge after the pulse end was ignored
module pulse_det
  import pulse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned MAX_SAMPLES = 4096
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  i_valid,
  input  logic [DATA_WIDTH-1:0]                 i_data,
  output logic                                  o_pulse,
  output logic [$clog2(MAX_SAMPLES+1)-1:0]      o_width,
  output logic [$clog2(DATA_WIDTH)-1:0]         o_offset,
  output logic                                  o_sat,
  output logic                                  o_missed
);

  localparam int unsigned WW   = $clog2(MAX_SAMPLES + 1);
  localparam int unsigned OW   = $clog2(DATA_WIDTH);
  localparam int unsigned RW   = $clog2(DATA_WIDTH + 1);
  localparam int unsigned SW   = ((WW > RW) ? WW : RW) + 1;
  localparam int          DW_I = int'(DATA_WIDTH);

  state_t          state;
  logic            prev;
  logic [WW-1:0]   acc_width;
  logic [OW-1:0]   acc_offset;

  logic            found;
  logic [OW-1:0]   edge_off;
  logic [RW-1:0]   run_len;
  logic            end_in_word;
  logic            extra_edge;

  int              lead_c;
  logic            hi_extra_c;
  logic [WW-1:0]   base_c;
  int              add_c;
  logic [SW-1:0]   sum_c;
  logic            sat_c;
  logic [WW-1:0]   width_c;

  pulse_scan #(.DATA_WIDTH(DATA_WIDTH)) u_scan (
    .word        (i_data),
    .prev        (prev),
    .found       (found),
    .edge_off    (edge_off),
    .run_len     (run_len),
    .end_in_word (end_in_word),
    .extra_edge  (extra_edge)
  );

  // Width update: a new run in IDLE, or the continuation of the open pulse in HIGH.
  always_comb begin
    lead_c     = lead_ones(MAX_DW'(i_data), DW_I);
    hi_extra_c = |(i_data << (lead_c + 1));
    if (state == HIGH) begin
      base_c = acc_width;
      add_c  = (&i_data) ? DW_I : lead_c;
    end else begin
      base_c = '0;
      add_c  = int'(run_len);
    end
    sum_c   = SW'(base_c) + SW'(add_c);
    sat_c   = (sum_c >= SW'(MAX_SAMPLES));
    width_c = sat_c ? WW'(MAX_SAMPLES) : WW'(sum_c);
  end

  // FSM, accumulator and report registers; nothing moves while i_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      prev       <= 1'b0;
      acc_width  <= '0;
      acc_offset <= '0;
      o_pulse    <= 1'b0;
      o_missed   <= 1'b0;
      o_sat      <= 1'b0;
      o_width    <= '0;
      o_offset   <= '0;
    end else begin
      o_pulse  <= 1'b0;
      o_missed <= 1'b0;
      if (i_valid) begin
        prev <= i_data[0];
        case (state)
          IDLE: begin
            if (found) begin
              if (end_in_word) begin
                o_pulse  <= 1'b1;
                o_width  <= width_c;
                o_sat    <= sat_c;
                o_offset <= edge_off;
                o_missed <= extra_edge;
              end else begin
                state      <= HIGH;
                acc_width  <= width_c;
                acc_offset <= edge_off;
              end
            end
          end
          HIGH: begin
            if (&i_data) begin
              acc_width <= width_c;
            end else begin
              // Terminating 0 at the end of the leading ones (MSB if it is 0).
              state    <= IDLE;
              o_pulse  <= 1'b1;
              o_width  <= width_c;
              o_sat    <= sat_c;
              o_offset <= acc_offset;
              o_missed <= hi_extra_c;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
